// File: rtl/gpu_mem_responder_if.sv
// GPU-side request/response and 64-bit memory-port signals of gpu_mem_responder.
// The responder connects through "slave"; whatever drives it (GPU plus memory model) uses "master".
interface gpu_mem_responder_if;
  logic         i_command;
  logic         o_busy;
  logic [1:0]   i_commandSize;
  logic         i_write;
  logic [14:0]  i_adr;
  logic [2:0]   i_subadr;
  logic [15:0]  i_writeMask;
  logic [255:0] i_dataOut;
  logic [255:0] o_dataIn;
  logic         o_dataInValid;
  logic         o_memReq;
  logic         i_memAck;
  logic         o_memWe;
  logic [16:0]  o_memAdr;
  logic [7:0]   o_memBE;
  logic [63:0]  o_memWData;
  logic [63:0]  i_memRData;
  logic         i_memRValid;

  modport slave (
    input  i_command, i_commandSize, i_write, i_adr, i_subadr, i_writeMask, i_dataOut,
           i_memAck, i_memRData, i_memRValid,
    output o_busy, o_dataIn, o_dataInValid, o_memReq, o_memWe, o_memAdr, o_memBE, o_memWData
  );

  modport master (
    output i_command, i_commandSize, i_write, i_adr, i_subadr, i_writeMask, i_dataOut,
           i_memAck, i_memRData, i_memRValid,
    input  o_busy, o_dataIn, o_dataInValid, o_memReq, o_memWe, o_memAdr, o_memBE, o_memWData
  );
endinterface

// File: rtl/gpu_mem_responder.sv
// Splits a GPU 4B/8B/32B block request into 64-bit memory beats, and gathers in-order
// read returns into a 256-bit lane-aligned buffer.
module gpu_mem_responder #(
  parameter int SKIP_EMPTY_BEATS = 1
) (
  input logic                i_clk,
  input logic                i_nrst,
  gpu_mem_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           write_q, write_d;
  logic [1:0]     size_q, size_d;
  logic [14:0]    adr_q, adr_d;
  logic [2:0]     subadr_q, subadr_d;
  logic [15:0]    mask_q, mask_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [1:0]     word_q, word_d;
  logic           memReq_q, memReq_d;
  logic [1:0]     retWord_q, retWord_d;
  logic [2:0]     outCnt_q, outCnt_d;
  logic [255:0]   rdBuf_q, rdBuf_d;
  logic           dataValid_q, dataValid_d;
  logic [2:0]     nextBeat;
  logic           ackAccept;
  logic           retAccept;

  function automatic logic inRange(input logic [1:0] size, input logic [2:0] sub,
                                   input logic [1:0] w);
    return (size == 2'd1) || (w == sub[2:1]);
  endfunction

  // One mask bit covers a 16-bit pixel, i.e. two byte enables; 4B requests keep only one half.
  function automatic logic [7:0] beatBe(input logic [15:0] mask, input logic [1:0] size,
                                        input logic [2:0] sub, input logic [1:0] w);
    logic [7:0] be;
    logic [7:0] half;
    for (int k = 0; k < 4; k++) be[2*k +: 2] = {2{mask[{w, 2'(k)}]}};
    half = (size == 2'd2) ? (sub[0] ? 8'hF0 : 8'h0F) : 8'hFF;
    return inRange(size, sub, w) ? (be & half) : 8'h00;
  endfunction

  // Lowest issuable word at or above "from"; bit 2 set means no beat is left.
  function automatic logic [2:0] findBeat(input logic wr, input logic [15:0] mask,
                                          input logic [1:0] size, input logic [2:0] sub,
                                          input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && inRange(size, sub, 2'(i)) &&
          (!wr || (SKIP_EMPTY_BEATS == 0) || (beatBe(mask, size, sub, 2'(i)) != 8'h00)))
        res = {1'b0, 2'(i)};
    end
    return res;
  endfunction

  assign ackAccept = memReq_q && bus.i_memAck;
  assign retAccept = bus.i_memRValid && (outCnt_q != 3'd0);

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    adr_d       = adr_q;
    subadr_d    = subadr_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    memReq_d    = memReq_q;
    retWord_d   = retWord_q;
    rdBuf_d     = rdBuf_q;
    dataValid_d = 1'b0;
    nextBeat    = 3'b100;
    outCnt_d    = outCnt_q + {2'b00, ackAccept && !write_q} - {2'b00, retAccept};

    // Returns come back in issue order, so the oldest outstanding lane is simply a counter.
    if (retAccept) begin
      rdBuf_d[{retWord_q, 6'd0} +: 64] = bus.i_memRData;
      retWord_d = retWord_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.i_command && !busy_q) begin
          write_d  = bus.i_write;
          size_d   = bus.i_commandSize;
          adr_d    = bus.i_adr;
          subadr_d = bus.i_subadr;
          mask_d   = bus.i_writeMask;
          wdata_d  = bus.i_dataOut;
          nextBeat = findBeat(bus.i_write, bus.i_writeMask, bus.i_commandSize,
                              bus.i_subadr, 3'd0);
          if (!bus.i_write) begin
            rdBuf_d   = '0;
            retWord_d = nextBeat[1:0];
          end
          if (nextBeat[2]) begin
            state_d = DONE;
          end else begin
            state_d  = bus.i_write ? WR_ISSUE : RD_ISSUE;
            memReq_d = 1'b1;
            word_d   = nextBeat[1:0];
          end
        end
      end
      WR_ISSUE, RD_ISSUE: begin
        if (ackAccept) begin
          nextBeat = findBeat(write_q, mask_q, size_q, subadr_q, {1'b0, word_q} + 3'd1);
          if (nextBeat[2]) begin
            memReq_d = 1'b0;
            state_d  = write_q ? DONE : RD_WAIT;
          end else begin
            word_d = nextBeat[1:0];
          end
        end
      end
      RD_WAIT: begin
        if (retAccept && (outCnt_q == 3'd1)) begin
          state_d     = DONE;
          dataValid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      adr_q       <= 15'd0;
      subadr_q    <= 3'd0;
      mask_q      <= 16'd0;
      wdata_q     <= '0;
      word_q      <= 2'd0;
      memReq_q    <= 1'b0;
      retWord_q   <= 2'd0;
      outCnt_q    <= 3'd0;
      rdBuf_q     <= '0;
      dataValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      write_q     <= write_d;
      size_q      <= size_d;
      adr_q       <= adr_d;
      subadr_q    <= subadr_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      word_q      <= word_d;
      memReq_q    <= memReq_d;
      retWord_q   <= retWord_d;
      outCnt_q    <= outCnt_d;
      rdBuf_q     <= rdBuf_d;
      dataValid_q <= dataValid_d;
    end
  end

  // Beat fields are derived from held registers, so they stay put until acknowledged.
  assign bus.o_busy        = busy_q;
  assign bus.o_memReq      = memReq_q;
  assign bus.o_memWe       = memReq_q && write_q;
  assign bus.o_memAdr      = memReq_q ? {adr_q, word_q} : 17'd0;
  assign bus.o_memBE       = !memReq_q ? 8'h00 :
                             (write_q ? beatBe(mask_q, size_q, subadr_q, word_q) : 8'hFF);
  assign bus.o_memWData    = (memReq_q && write_q) ? wdata_q[{word_q, 6'd0} +: 64] : 64'd0;
  assign bus.o_dataIn      = rdBuf_q;
  assign bus.o_dataInValid = dataValid_q;

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Randomized scoreboard bench for gpu_mem_responder: commands push expected beats and
// read results; a memory agent and a read monitor pop and compare as the DUT presents them.
module tb_gpu_mem_responder;

  typedef struct {
    logic [16:0] adr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
  } beat_t;

  typedef struct {
    int          readyCyc;
    logic [16:0] adr;
  } ret_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  gpu_mem_responder_if bus();

  gpu_mem_responder #(.SKIP_EMPTY_BEATS(1)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  beat_t        expBeats[$];
  logic [255:0] expReads[$];
  ret_t         retQ[$];
  int           ackPct = 100;
  int           retMin = 0;
  int           retMax = 0;
  int           stallCycles = 0;
  bit           simpleMem = 1'b0;
  bit           strayEn = 1'b0;
  int           acceptCyc = 0;
  int           validCyc = 0;
  int           beatsSeen = 0;
  int           lastReady = 0;
  bit           ackNow = 1'b0;
  bit           prevReq = 1'b0;
  logic [16:0]  obsAdr;
  logic         obsWe;
  logic [7:0]   obsBe;
  logic [63:0]  obsWData;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] memWord(input logic [16:0] a);
    if (simpleMem) return 64'hA0 + 64'(a[1:0]);
    return {15'h0, a, 32'h0} ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Reference: beats and read result straight from the block/size/mask rules, byte by byte.
  task automatic modelCommand(input logic wr, input logic [1:0] size, input logic [14:0] adr,
                              input logic [2:0] sub, input logic [15:0] mask,
                              input logic [255:0] data);
    int           firstW;
    int           lastW;
    logic [255:0] rd;
    beat_t        b;
    if (size == 2'd1) begin
      firstW = 0;
      lastW  = 3;
    end else begin
      firstW = int'(sub[2:1]);
      lastW  = firstW;
    end
    rd = '0;
    for (int w = firstW; w <= lastW; w++) begin
      b.adr   = {adr, 2'(w)};
      b.we    = wr;
      b.wdata = data[64*w +: 64];
      b.be    = 8'hFF;
      if (wr) begin
        for (int byteIdx = 0; byteIdx < 8; byteIdx++)
          b.be[byteIdx] = mask[4*w + byteIdx/2] &&
                          ((size != 2'd2) || ((byteIdx/4) == int'(sub[0])));
      end else begin
        rd[64*w +: 64] = memWord(b.adr);
      end
      if (!(wr && (b.be == 8'h00))) expBeats.push_back(b);
    end
    if (!wr) expReads.push_back(rd);
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic [14:0] adr,
                               input logic [2:0] sub, input logic [15:0] mask,
                               input logic [255:0] data, input bit holdHigh);
    int guard;
    bus.i_write       = wr;
    bus.i_commandSize = size;
    bus.i_adr         = adr;
    bus.i_subadr      = sub;
    bus.i_writeMask   = mask;
    bus.i_dataOut     = data;
    bus.i_command     = 1'b1;
    guard = 0;
    while (bus.o_busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checkOutput("acceptTimeout", 256'(bus.o_busy), 256'(0));
    end else begin
      acceptCyc = cyc;
      modelCommand(wr, size, adr, sub, mask, data);
    end
    @(negedge clk);
    if (!holdHigh) bus.i_command = 1'b0;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((expBeats.size() != 0 || expReads.size() != 0 || retQ.size() != 0 || bus.o_busy)
           && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) checkOutput("drainTimeout", 256'(expBeats.size() + expReads.size()), 256'(0));
  endtask

  function automatic logic [255:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Memory agent: acks, in-order delayed returns, stray returns, beat scoreboard, hold checks.
  initial begin
    beat_t b;
    ret_t  r;
    bus.i_memAck    = 1'b0;
    bus.i_memRValid = 1'b0;
    bus.i_memRData  = 64'd0;
    forever begin
      @(negedge clk);
      if (ackNow) begin
        beatsSeen++;
        if (expBeats.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedBeat: got adr %0h want none", obsAdr);
        end else begin
          b = expBeats.pop_front();
          checkOutput("beatAdr", 256'(obsAdr), 256'(b.adr));
          checkOutput("beatWe", 256'(obsWe), 256'(b.we));
          checkOutput("beatBe", 256'(obsBe), 256'(b.be));
          if (b.we) checkOutput("beatData", 256'(obsWData), 256'(b.wdata));
        end
        if (!obsWe) begin
          r.adr      = obsAdr;
          r.readyCyc = cyc + int'($urandom_range(retMax, retMin));
          if (r.readyCyc < lastReady) r.readyCyc = lastReady;
          lastReady  = r.readyCyc;
          retQ.push_back(r);
        end
      end else if (prevReq) begin
        checkOutput("holdReq", 256'(bus.o_memReq), 256'(1));
        checkOutput("holdFields", 256'({bus.o_memAdr, bus.o_memWe, bus.o_memBE, bus.o_memWData}),
                    256'({obsAdr, obsWe, obsBe, obsWData}));
      end
      obsAdr   = bus.o_memAdr;
      obsWe    = bus.o_memWe;
      obsBe    = bus.o_memBE;
      obsWData = bus.o_memWData;
      prevReq  = bus.o_memReq;
      if (bus.o_memReq) begin
        if (stallCycles > 0) begin
          stallCycles--;
          ackNow = 1'b0;
          checkOutput("busyInStall", 256'(bus.o_busy), 256'(1));
        end else begin
          ackNow = (int'($urandom_range(99)) < ackPct);
        end
      end else begin
        ackNow = 1'b0;
      end
      bus.i_memAck = ackNow;
      if (retQ.size() != 0 && retQ[0].readyCyc <= cyc) begin
        r = retQ.pop_front();
        bus.i_memRValid = 1'b1;
        bus.i_memRData  = memWord(r.adr);
      end else if (strayEn && retQ.size() == 0 && $urandom_range(7) == 0) begin
        bus.i_memRValid = 1'b1;
        bus.i_memRData  = {$urandom(), $urandom()};
      end else begin
        bus.i_memRValid = 1'b0;
        bus.i_memRData  = 64'd0;
      end
    end
  end

  // Read-result monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_dataInValid) begin
        validCyc = cyc;
        if (expReads.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpectedValid: got %0h want none", bus.o_dataIn);
        end else begin
          checkOutput("readData", bus.o_dataIn, expReads.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    nrst              = 1'b0;
    bus.i_command     = 1'b0;
    bus.i_commandSize = 2'd0;
    bus.i_write       = 1'b0;
    bus.i_adr         = 15'd0;
    bus.i_subadr      = 3'd0;
    bus.i_writeMask   = 16'd0;
    bus.i_dataOut     = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", 256'(bus.o_busy), 256'(0));
    checkOutput("rstMemReq", 256'(bus.o_memReq), 256'(0));
    checkOutput("rstMemFields", 256'({bus.o_memWe, bus.o_memBE, bus.o_memAdr, bus.o_memWData}), 256'(0));
    checkOutput("rstValid", 256'(bus.o_dataInValid), 256'(0));
    checkOutput("rstDataIn", bus.o_dataIn, 256'(0));
    nrst = 1'b1;
    @(negedge clk);

    // 32B read, 1-cycle returns, ack every cycle: addresses, data, latency.
    simpleMem = 1'b1;
    applyStimulus(1'b0, 2'd1, 15'h1234, 3'd0, 16'h0, 256'd0, 1'b0);
    waitIdle();
    checkOutput("readLatency", 256'(validCyc - acceptCyc), 256'(6));
    checkOutput("blockReadData", bus.o_dataIn, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    simpleMem = 1'b0;

    beatsSeen = 0;
    applyStimulus(1'b1, 2'd1, 15'h0ABC, 3'd0, 16'h00F0, randData(), 1'b0);
    waitIdle();
    checkOutput("sparseWriteBeats", 256'(beatsSeen), 256'(1));

    beatsSeen = 0;
    applyStimulus(1'b1, 2'd2, 15'h0123, 3'd5, 16'hFFFF, randData(), 1'b0);
    waitIdle();
    checkOutput("halfWriteBeats", 256'(beatsSeen), 256'(1));

    beatsSeen = 0;
    applyStimulus(1'b1, 2'd1, 15'h0077, 3'd0, 16'h0000, randData(), 1'b0);
    waitIdle();
    checkOutput("emptyWriteBeats", 256'(beatsSeen), 256'(0));

    stallCycles = 3;
    applyStimulus(1'b0, 2'd3, 15'h0456, 3'd6, 16'h0, 256'd0, 1'b0);
    waitIdle();

    // Reset while waiting on returns; late returns must be dropped.
    retMin = 8;
    retMax = 8;
    applyStimulus(1'b0, 2'd1, 15'h2222, 3'd0, 16'h0, 256'd0, 1'b0);
    guard = 0;
    while (!(bus.o_busy && !bus.o_memReq && retQ.size() <= 2) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reachWait", 256'(guard < 100), 256'(1));
    nrst = 1'b0;
    expReads.delete();
    @(negedge clk);
    checkOutput("midRstBusy", 256'(bus.o_busy), 256'(0));
    checkOutput("midRstDataIn", bus.o_dataIn, 256'(0));
    checkOutput("midRstMem", 256'({bus.o_memReq, bus.o_memBE, bus.o_memAdr}), 256'(0));
    nrst = 1'b1;
    waitIdle();
    checkOutput("lateReturnDataIn", bus.o_dataIn, 256'(0));
    retMin = 0;
    retMax = 2;
    applyStimulus(1'b0, 2'd1, 15'h3333, 3'd0, 16'h0, 256'd0, 1'b0);
    waitIdle();

    // Randomized traffic, command often held high across accepts.
    strayEn = 1'b1;
    for (int n = 0; n < 60; n++) begin
      bit hold;
      ackPct = int'($urandom_range(100, 30));
      retMin = int'($urandom_range(1));
      retMax = retMin + int'($urandom_range(3));
      hold   = 1'($urandom_range(1));
      applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), 15'($urandom()),
                    3'($urandom_range(7)), 16'($urandom()), randData(), hold);
      if (!hold) repeat ($urandom_range(2)) @(negedge clk);
    end
    bus.i_command = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("leftoverBeats", 256'(expBeats.size()), 256'(0));
    checkOutput("leftoverReads", 256'(expReads.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
